// File: rtl/control_muestreo_adc.sv
// Periodic ADC sampling controller: requests conversions every PERIODO cycles, watches for
// done timeouts, and averages 2^L samples into Dato_promedio.
module control_muestreo_adc #(
  parameter int unsigned PERIODO = 31250,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned L       = 2
) (
  input  logic        Clock_Nexys,
  input  logic        Reset,
  input  logic        enable,
  input  logic        done,
  input  logic [11:0] Dato,
  output logic        start,
  output logic [11:0] Dato_promedio,
  output logic        valido,
  output logic        error_timeout,
  output logic        ocupado
);

  localparam int unsigned PW = $clog2(PERIODO + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned AW = 12 + L;

  localparam logic [PW-1:0] PER_RECARGA = PW'(PERIODO - 1);
  localparam logic [TW-1:0] TO_ULTIMO   = TW'(TIMEOUT - 1);
  localparam logic [L:0]    N_MUESTRAS  = (L + 1)'(1) << L;

  typedef enum logic [1:0] {REPOSO, ESPERA, SOLICITA, CAPTURA} estado_t;

  estado_t       estado;
  logic          done_s1, done_s2, done_prev;
  logic [PW-1:0] per_cnt;
  logic [TW-1:0] to_cnt;
  logic [AW-1:0] acc;
  logic [L:0]    cnt;

  logic          evento;
  logic [AW-1:0] suma;
  logic [L:0]    cnt_sig;

  assign evento  = done_s2 & ~done_prev;
  assign suma    = acc + AW'(Dato);
  assign cnt_sig = cnt + 1'b1;
  assign ocupado = (estado != REPOSO);

  always_ff @(posedge Clock_Nexys) begin
    if (Reset) begin
      estado        <= REPOSO;
      done_s1       <= 1'b0;
      done_s2       <= 1'b0;
      done_prev     <= 1'b0;
      per_cnt       <= '0;
      to_cnt        <= '0;
      acc           <= '0;
      cnt           <= '0;
      start         <= 1'b0;
      valido        <= 1'b0;
      error_timeout <= 1'b0;
      Dato_promedio <= '0;
    end else begin
      done_s1   <= done;
      done_s2   <= done_s1;
      done_prev <= done_s2;
      valido    <= 1'b0;
      if (!enable) begin
        estado  <= REPOSO;
        start   <= 1'b0;
        per_cnt <= '0;
        to_cnt  <= '0;
        acc     <= '0;
        cnt     <= '0;
      end else begin
        unique case (estado)
          REPOSO: begin
            estado        <= SOLICITA;
            start         <= 1'b1;
            per_cnt       <= PER_RECARGA;
            to_cnt        <= '0;
            error_timeout <= 1'b0;
          end
          ESPERA: begin
            if (per_cnt == '0) begin
              estado  <= SOLICITA;
              start   <= 1'b1;
              per_cnt <= PER_RECARGA;
              to_cnt  <= '0;
            end else begin
              per_cnt <= per_cnt - 1'b1;
            end
          end
          SOLICITA: begin
            // Period counter saturates at 0 so at most one period is held pending.
            if (per_cnt != '0) per_cnt <= per_cnt - 1'b1;
            if (evento) begin
              estado <= CAPTURA;
              start  <= 1'b0;
            end else if (to_cnt == TO_ULTIMO) begin
              estado        <= ESPERA;
              start         <= 1'b0;
              error_timeout <= 1'b1;
              acc           <= '0;
              cnt           <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          CAPTURA: begin
            if (cnt_sig == N_MUESTRAS) begin
              Dato_promedio <= suma[AW-1:L];
              valido        <= 1'b1;
              acc           <= '0;
              cnt           <= '0;
            end else begin
              acc <= suma;
              cnt <= cnt_sig;
            end
            if (per_cnt == '0) begin
              estado  <= SOLICITA;
              start   <= 1'b1;
              per_cnt <= PER_RECARGA;
              to_cnt  <= '0;
            end else begin
              estado  <= ESPERA;
              per_cnt <= per_cnt - 1'b1;
            end
          end
          default: estado <= REPOSO;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_control_muestreo_adc.sv
// Directed bench for control_muestreo_adc with PERIODO=10, TIMEOUT=20, L=2.
module tb_control_muestreo_adc;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        done;
  logic [11:0] dato;
  logic        start;
  logic [11:0] promedio;
  logic        valido;
  logic        err_to;
  logic        ocupado;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int nvalid = 0;

  control_muestreo_adc #(
    .PERIODO(10),
    .TIMEOUT(20),
    .L      (2)
  ) dut (
    .Clock_Nexys  (clk),
    .Reset        (rst),
    .enable       (enable),
    .done         (done),
    .Dato         (dato),
    .start        (start),
    .Dato_promedio(promedio),
    .valido       (valido),
    .error_timeout(err_to),
    .ocupado      (ocupado)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (valido === 1'b1) nvalid <= nvalid + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input logic lvl, input int limit, output int n);
    n = 0;
    while (start !== lvl && n < limit) begin
      tick();
      n++;
    end
    check("wait_start", {31'd0, start}, {31'd0, lvl});
  endtask

  // One well-behaved conversion: done raised once start is seen, held through capture.
  task automatic conv(input logic [11:0] x, output int t_start);
    int n;
    wait_start(1'b1, 40, n);
    t_start = cyc;
    dato = x;
    done = 1'b1;
    wait_start(1'b0, 40, n);
    check("latencia", n, 3);
    tick();
    done = 1'b0;
    tick();
  endtask

  initial begin
    int n, t1, t2, t3, t4;

    // Reset with enable and done asserted
    rst = 1'b1; enable = 1'b1; done = 1'b1; dato = 12'd0;
    tick(); tick();
    check("rst_start", {31'd0, start}, 0);
    check("rst_valido", {31'd0, valido}, 0);
    check("rst_error", {31'd0, err_to}, 0);
    check("rst_ocupado", {31'd0, ocupado}, 0);
    check("rst_promedio", {20'd0, promedio}, 0);
    rst = 1'b0; done = 1'b0;
    tick();
    check("start_tras_rst", {31'd0, start}, 1);
    check("ocupado_activo", {31'd0, ocupado}, 1);

    // Four conversions averaging to 250
    conv(12'd100, t1);
    conv(12'd200, t2);
    conv(12'd300, t3);
    check("sin_valido_parcial", nvalid, 0);
    check("promedio_sin_cambio", {20'd0, promedio}, 0);
    conv(12'd403, t4);
    check("un_valido", nvalid, 1);
    check("promedio_250", {20'd0, promedio}, 250);
    check("periodo_1", t2 - t1, 10);
    check("periodo_2", t3 - t2, 10);
    check("periodo_3", t4 - t3, 10);

    // No done: timeout after 20 cycles of start
    wait_start(1'b1, 40, n);
    wait_start(1'b0, 40, n);
    check("alto_timeout", n, 20);
    check("error_set", {31'd0, err_to}, 1);
    wait_start(1'b1, 40, n);
    check("error_retenido", {31'd0, err_to}, 1);
    check("valido_sin_cambio", nvalid, 1);

    // Disable: error and average retained; re-enable clears error
    enable = 1'b0;
    tick();
    check("reposo_ocupado", {31'd0, ocupado}, 0);
    check("reposo_start", {31'd0, start}, 0);
    check("reposo_error", {31'd0, err_to}, 1);
    check("reposo_promedio", {20'd0, promedio}, 250);
    enable = 1'b1;
    tick();
    check("reinicio_start", {31'd0, start}, 1);
    check("reinicio_error", {31'd0, err_to}, 0);

    // done edge lands on the timeout-expiry cycle
    repeat (17) tick();
    dato = 12'd400;
    done = 1'b1;
    wait_start(1'b0, 10, n);
    check("latencia_limite", n, 3);
    check("limite_sin_error", {31'd0, err_to}, 0);
    tick();
    done = 1'b0;
    check("limite_error_post", {31'd0, err_to}, 0);
    tick();
    conv(12'd400, t1);
    conv(12'd400, t1);
    conv(12'd400, t1);
    check("limite_promedio", {20'd0, promedio}, 400);
    check("limite_valido", nvalid, 2);

    // Partial samples discarded by disable, then full-scale average
    conv(12'h800, t1);
    conv(12'h800, t1);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    check("rearranque_start", {31'd0, start}, 1);
    conv(12'hFFF, t1);
    conv(12'hFFF, t1);
    conv(12'hFFF, t1);
    conv(12'hFFF, t1);
    check("promedio_fff", {20'd0, promedio}, 32'hFFF);
    check("valido_fff", nvalid, 3);

    // done held high across two requests: second one times out
    wait_start(1'b1, 40, n);
    dato = 12'd50;
    done = 1'b1;
    wait_start(1'b0, 10, n);
    check("latencia_alto", n, 3);
    wait_start(1'b1, 40, n);
    wait_start(1'b0, 40, n);
    check("alto_sin_doble", n, 20);
    check("alto_error", {31'd0, err_to}, 1);
    check("alto_valido", nvalid, 3);
    done = 1'b0;

    // Reset mid-run overrides everything
    rst = 1'b1;
    tick();
    check("rst2_start", {31'd0, start}, 0);
    check("rst2_error", {31'd0, err_to}, 0);
    check("rst2_ocupado", {31'd0, ocupado}, 0);
    check("rst2_promedio", {20'd0, promedio}, 0);
    check("rst2_valido", {31'd0, valido}, 0);
    rst = 1'b0; enable = 1'b0;
    tick();
    check("final_ocupado", {31'd0, ocupado}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
